// File: rtl/pe27_requant_if.sv
// Stream bundle between the MAC, the requant stage and the feature-map writer.
// master: the side that produces MAC results and consumes quantized outputs.
// slave:  the requant stage.
interface pe27_requant_if #(
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned CH_W   = 4,
  parameter int unsigned CNT_W  = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ACC_W-1:0]         in_acc;
  logic signed [BIAS_W-1:0] bias;
  logic [4:0]               shift;
  logic                     relu_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_last;
  logic [CNT_W-1:0]         fifo_count;

  modport master (
    output in_valid, in_acc, bias, shift, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last, fifo_count
  );

  modport slave (
    input  in_valid, in_acc, bias, shift, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last, fifo_count
  );
endinterface

// File: rtl/pe27_requant_out.sv
// Requantization stage after the 27-term PE MAC: bias add, optional ReLU,
// round-half-up right shift, saturation to OUT_W bits, channel tagging and a
// small output FIFO. Admission is credit based so the FIFO never overflows.
module pe27_requant_out #(
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned BIAS_W     = 16,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_CH     = 16
) (
  input  logic            clk,
  input  logic            rst,
  pe27_requant_if.slave   bus
);
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned SUM_W = ACC_W + 2;
  localparam int unsigned RND_W = SUM_W + 1;

  localparam logic signed [RND_W-1:0] UMAX = RND_W'(int'(2 ** OUT_W) - 1);
  localparam logic signed [RND_W-1:0] SMAX = RND_W'(int'(2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] SMIN = RND_W'(-int'(2 ** (OUT_W - 1)));

  // S1 registers: biased sum plus the controls sampled with it
  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic [CH_W-1:0]         s1_ch;
  logic [4:0]              s1_shift;
  logic                    s1_relu;

  // S2 registers: quantized result waiting to enter the FIFO
  logic                    s2_valid;
  logic [OUT_W-1:0]        s2_data;
  logic [CH_W-1:0]         s2_ch;

  logic [CH_W-1:0]         ch_cnt;
  logic                    in_ready_q;

  logic [OUT_W-1:0]        mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]         mem_ch   [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;

  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [CNT_W-1:0]        count_nxt;
  logic                    in_ready_nxt;

  logic signed [RND_W-1:0] relu_in;
  logic signed [RND_W-1:0] half;
  logic signed [RND_W-1:0] rounded;
  logic [OUT_W-1:0]        q_c;

  assign accept = bus.in_valid & in_ready_q;
  assign push   = s2_valid;
  assign pop    = (count != '0) & bus.out_ready;

  // ReLU, round-half-up shift and saturation of the S1 sum
  always_comb begin
    relu_in = RND_W'(s1_sum);
    half    = '0;
    if (s1_relu && s1_sum[SUM_W-1]) relu_in = '0;
    if (s1_shift != 5'd0) half = RND_W'(1) <<< (s1_shift - 5'd1);
    rounded = (relu_in + half) >>> s1_shift;
    if (s1_relu) begin
      if (rounded > UMAX)           q_c = UMAX[OUT_W-1:0];
      else if (rounded[RND_W-1])    q_c = '0;
      else                          q_c = rounded[OUT_W-1:0];
    end else begin
      if (rounded > SMAX)           q_c = SMAX[OUT_W-1:0];
      else if (rounded < SMIN)      q_c = SMIN[OUT_W-1:0];
      else                          q_c = rounded[OUT_W-1:0];
    end
  end

  // Next occupancy and the credit check that gates the next acceptance
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
    in_ready_nxt = (OCC_W'(count_nxt) + OCC_W'(accept) + OCC_W'(s1_valid))
                   < OCC_W'(FIFO_DEPTH);
  end

  // Pipeline stages, channel counter and registered credit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sum     <= '0;
      s1_ch      <= '0;
      s1_shift   <= '0;
      s1_relu    <= 1'b0;
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_ch      <= '0;
      ch_cnt     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum   <= $signed({2'b00, bus.in_acc}) + SUM_W'(bus.bias);
        s1_ch    <= ch_cnt;
        s1_shift <= bus.shift;
        s1_relu  <= bus.relu_en;
        ch_cnt   <= (ch_cnt == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt + CH_W'(1);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= q_c;
        s2_ch   <= s1_ch;
      end
      in_ready_q <= in_ready_nxt;
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_ch[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= s2_data;
        mem_ch[wr_ptr]   <= s2_ch;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (count != '0);
  assign bus.out_data   = mem_data[rd_ptr];
  assign bus.out_ch     = mem_ch[rd_ptr];
  assign bus.out_last   = (mem_ch[rd_ptr] == CH_W'(NUM_CH - 1));
  assign bus.fifo_count = count;
endmodule
